// File: rtl/demux_dispatch_pkg.sv
// demux_dispatch shared constants and slot-state encoding.
// Optional per-channel drain counters: DEMUX_STATS_EN.
package demux_dispatch_pkg;

  localparam int DEMUX_CH     = 4;
  localparam int DEMUX_SEL_W  = 2;
  localparam int DEMUX_STAT_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  function automatic logic [DEMUX_CH-1:0] sel_onehot(
    input logic [DEMUX_SEL_W-1:0] sel
  );
    logic [DEMUX_CH-1:0] oh;
    oh = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot of the dispatcher with valid/ready drain.
// DEMUX_STATS_EN adds a saturating drain counter.
module demux_slot
  import demux_dispatch_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [WIDTH-1:0]        data,
  input  logic                    ready,
`ifdef DEMUX_STATS_EN
  output logic [DEMUX_STAT_W-1:0] count,
`endif
  output logic [WIDTH-1:0]        q,
  output logic                    valid
);

  slot_state_e state_q;
  slot_state_e state_d;
  logic        drain;

  assign drain = (state_q == FULL) && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // A load in the same cycle as a drain keeps the slot full.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL:  if (drain && !load) state_d = EMPTY;
    endcase
  end

  always_comb begin
    valid = (state_q == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= data;
  end

`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (drain && (count != '1))
      count <= count + DEMUX_STAT_W'(1);
  end
`endif

endmodule

// File: rtl/demux_dispatch.sv
// Registered 1-to-4 demux with per-channel one-entry slots.
// DEMUX_STATS_EN exposes per-channel drain counters on stat_count.
module demux_dispatch
  import demux_dispatch_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [WIDTH-1:0]                 Data_in,
  input  logic [DEMUX_SEL_W-1:0]           select,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [WIDTH-1:0]                 Data_out_0,
  output logic [WIDTH-1:0]                 Data_out_1,
  output logic [WIDTH-1:0]                 Data_out_2,
  output logic [WIDTH-1:0]                 Data_out_3,
  output logic [DEMUX_CH-1:0]              out_valid,
`ifdef DEMUX_STATS_EN
  output logic [DEMUX_CH*DEMUX_STAT_W-1:0] stat_count,
`endif
  input  logic [DEMUX_CH-1:0]              out_ready
);

  logic                fire;
  logic [DEMUX_CH-1:0] load;
  logic [WIDTH-1:0]    slot_q [DEMUX_CH];

  // Only the addressed slot gates acceptance; others never block.
  assign in_ready = !out_valid[select] || out_ready[select];
  assign fire     = in_valid && in_ready;

  always_comb begin
    load = '0;
    if (fire) load = sel_onehot(select);
  end

  for (genvar k = 0; k < DEMUX_CH; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .data  (Data_in),
      .ready (out_ready[k]),
`ifdef DEMUX_STATS_EN
      .count (stat_count[k*DEMUX_STAT_W +: DEMUX_STAT_W]),
`endif
      .q     (slot_q[k]),
      .valid (out_valid[k])
    );
  end

  assign Data_out_0 = slot_q[0];
  assign Data_out_1 = slot_q[1];
  assign Data_out_2 = slot_q[2];
  assign Data_out_3 = slot_q[3];

endmodule

// File: tb/tb_demux_dispatch.sv
// Self-checking bench for demux_dispatch: vector table, corner sequences,
// random traffic vs a reference model; DEMUX_STATS_EN adds counter tests.
module tb_demux_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  Data_in = '0;
  logic [1:0]  select = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  Data_out_0, Data_out_1, Data_out_2, Data_out_3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
`ifdef DEMUX_STATS_EN
  logic [63:0] stat_count;
`endif

  int errors = 0;
  int checks = 0;

  demux_dispatch #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Data_in    (Data_in),
    .select     (select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Data_out_0 (Data_out_0),
    .Data_out_1 (Data_out_1),
    .Data_out_2 (Data_out_2),
    .Data_out_3 (Data_out_3),
    .out_valid  (out_valid),
`ifdef DEMUX_STATS_EN
    .stat_count (stat_count),
`endif
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  logic [7:0] dq [4];
  assign dq[0] = Data_out_0;
  assign dq[1] = Data_out_1;
  assign dq[2] = Data_out_2;
  assign dq[3] = Data_out_3;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: four boxes, each either holding a word or not.
  bit         mv [4];
  logic [7:0] md [4];

  always @(posedge clk or negedge rst_n) begin
    bit acc;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        mv[k] = 0;
        md[k] = '0;
      end
    end else begin
      acc = in_valid && (!mv[select] || out_ready[select]);
      for (int k = 0; k < 4; k++) begin
        if (acc && (int'(select) == k)) begin
          md[k] = Data_in;
          mv[k] = 1;
        end else if (mv[k] && out_ready[k]) begin
          mv[k] = 0;
        end
      end
    end
  end

  function automatic logic [3:0] model_valid();
    return {mv[3], mv[2], mv[1], mv[0]};
  endfunction

  // Producer must hold select/data while an offer is stalled.
  logic       stalled_q = 1'b0;
  logic [1:0] sel_q = '0;
  logic [7:0] din_q = '0;

  always @(posedge clk) begin
    if (rst_n && stalled_q && in_valid) begin
      checks++;
      if (select !== sel_q || Data_in !== din_q) begin
        errors++;
        $display("FAIL producer_hold: got sel=%0d data=%0h expected sel=%0d data=%0h",
                 select, Data_in, sel_q, din_q);
      end
    end
    stalled_q = rst_n && in_valid && !in_ready;
    sel_q     = select;
    din_q     = Data_in;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s,
                       input logic [7:0] d, input logic [3:0] r);
    in_valid  = v;
    select    = s;
    Data_in   = d;
    out_ready = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic       v;
    logic [1:0] s;
    logic [7:0] d;
    logic [3:0] r;
    logic       ir;
    logic [3:0] ov;
    int         ch;
    logic [7:0] cd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit st;

    tbl[0] = '{1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0100, 2, 8'hA5};
    tbl[1] = '{1'b0, 2'd2, 8'h00, 4'b0000, 1'b0, 4'b0100, 2, 8'hA5};
    tbl[2] = '{1'b0, 2'd2, 8'h00, 4'b0100, 1'b1, 4'b0000, 2, 8'hA5};
    tbl[3] = '{1'b1, 2'd1, 8'h5A, 4'b0000, 1'b1, 4'b0010, 1, 8'h5A};
    tbl[4] = '{1'b1, 2'd1, 8'h11, 4'b0000, 1'b0, 4'b0010, 1, 8'h5A};
    tbl[5] = '{1'b0, 2'd1, 8'h11, 4'b0000, 1'b0, 4'b0010, 1, 8'h5A};
    tbl[6] = '{1'b1, 2'd3, 8'h33, 4'b0000, 1'b1, 4'b1010, 3, 8'h33};
    tbl[7] = '{1'b1, 2'd1, 8'h11, 4'b0010, 1'b1, 4'b1010, 1, 8'h11};
    tbl[8] = '{1'b0, 2'd0, 8'h00, 4'b1010, 1'b1, 4'b0000, 3, 8'h33};
    tbl[9] = '{1'b1, 2'd0, 8'hC3, 4'b1111, 1'b1, 4'b0001, 0, 8'hC3};

    // Reset state while held in reset and just after release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rst_data%0d", k), 32'(dq[k]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_valid", 32'(out_valid), 32'h0);
    chk("idle_ready", 32'(in_ready), 32'h1);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      tick();
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_data%0d", i, tbl[i].ch),
          32'(dq[tbl[i].ch]), 32'(tbl[i].cd));
    end

    // Word held across 10 stalled cycles, then drained
    drive(1'b1, 2'd2, 8'h77, 4'b0000);
    tick();
    drive(1'b0, 2'd2, 8'h77, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold%0d_valid2", i), 32'(out_valid[2]), 32'h1);
      chk($sformatf("hold%0d_data2", i), 32'(Data_out_2), 32'h77);
      tick();
    end
    out_ready = 4'b0100;
    tick();
    chk("hold_drained", 32'(out_valid[2]), 32'h0);
    chk("hold_data_kept", 32'(Data_out_2), 32'h77);
    drive(1'b0, 2'd0, 8'h00, 4'b1111);
    tick();

    // Streaming 100 words back-to-back into channel 0
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 2'd0, 8'(i), 4'b0001);
      #1;
      chk($sformatf("stream%0d_ready", i), 32'(in_ready), 32'h1);
      tick();
      chk($sformatf("stream%0d_data", i), 32'(Data_out_0), 32'(i));
      chk($sformatf("stream%0d_valid", i), 32'(out_valid[0]), 32'h1);
    end
    drive(1'b0, 2'd0, 8'h00, 4'b0001);
    tick();
    chk("stream_end_valid", 32'(out_valid), 32'h0);

    // Asynchronous reset with all four slots full
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 8'(8'h10 + k), 4'b0000);
      tick();
    end
    drive(1'b0, 2'd0, 8'h00, 4'b0000);
    chk("full_before_rst", 32'(out_valid), 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_ready", 32'(in_ready), 32'h1);
    for (int k = 0; k < 4; k++)
      chk($sformatf("async_rst_data%0d", k), 32'(dq[k]), 32'h0);
    drive(1'b1, 2'd1, 8'hEE, 4'b1111);
    tick();
    chk("in_rst_valid", 32'(out_valid), 32'h0);
    chk("in_rst_data1", 32'(Data_out_1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'h0);

    // Random traffic against the reference model
    st = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!st) begin
        in_valid = ($urandom_range(0, 3) != 0);
        select   = 2'($urandom);
        Data_in  = 8'($urandom);
      end
      out_ready = 4'($urandom);
      #1;
      chk("rand_in_ready", 32'(in_ready),
          32'(!mv[select] || out_ready[select]));
      st = in_valid && !in_ready;
      tick();
      chk("rand_out_valid", 32'(out_valid), 32'(model_valid()));
      for (int k = 0; k < 4; k++)
        chk($sformatf("rand_data%0d", k), 32'(dq[k]), 32'(md[k]));
    end

`ifdef DEMUX_STATS_EN
    do_reset();
    chk("stat_rst", 32'(stat_count == 64'h0), 32'h1);
    drive(1'b1, 2'd1, 8'h55, 4'b0010);
    repeat (65536) @(posedge clk);
    #1;
    chk("stat1_at_max", 32'(stat_count[31:16]), 32'hFFFF);
    repeat (4464) @(posedge clk);
    #1;
    drive(1'b0, 2'd1, 8'h55, 4'b0010);
    tick();
    chk("stat1_saturated", 32'(stat_count[31:16]), 32'hFFFF);
    drive(1'b1, 2'd0, 8'h01, 4'b0001);
    repeat (3) tick();
    in_valid = 1'b0;
    tick();
    chk("stat0_three", 32'(stat_count[15:0]), 32'h3);
    chk("stat1_still", 32'(stat_count[31:16]), 32'hFFFF);
    chk("stat2_zero", 32'(stat_count[47:32]), 32'h0);
    chk("stat3_zero", 32'(stat_count[63:48]), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
